// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Response owed in the cycle after a grant.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      F_RD  = 3'd1,
      L_RD  = 3'd2,
      L_WR  = 3'd3,
      F_ERR = 3'd4,
      L_ERR = 3'd5
   } pend_t;

   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_words);
      return (addr[1:0] == 2'b00) && ({32'd0, addr} < (64'(mem_words) << 2));
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if #(parameter int AW = 9);
   logic          fetch_req_valid;
   logic          fetch_req_ready;
   logic [31:0]   fetch_addr;
   logic          fetch_flush;
   logic          fetch_rsp_valid;
   logic [31:0]   fetch_rsp_data;
   logic          fetch_rsp_err;

   logic          ld_req_valid;
   logic          ld_req_ready;
   logic          ld_we;
   logic [31:0]   ld_addr;
   logic [31:0]   ld_wdata;
   logic [3:0]    ld_wstrb;
   logic          ld_rsp_valid;
   logic [31:0]   ld_rsp_data;
   logic          ld_rsp_err;

   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  fetch_req_valid, fetch_addr, fetch_flush,
      input  ld_req_valid, ld_we, ld_addr, ld_wdata, ld_wstrb,
      input  mem_rdata,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
      output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output fetch_req_valid, fetch_addr, fetch_flush,
      output ld_req_valid, ld_we, ld_addr, ld_wdata, ld_wstrb,
      output mem_rdata,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
      input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_arbiter_starve_ctr.sv
// Saturating count of cycles fetch has been refused; at_limit forces a fetch win.
module imem_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   logic [3:0] cnt;

   assign at_limit = (cnt == 4'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (inc && !at_limit) cnt <= cnt + 4'd1;
   end
endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the loader;
// responses come one cycle after the grant, driven from the pending state.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter  int MEM_WORDS    = 512,
   parameter  int STARVE_LIMIT = 4,
   localparam int AW           = $clog2(MEM_WORDS)
) (
   input logic           clk,
   input logic           rst_n,
   imem_arbiter_if.slave bus
);
   logic        f_ok, l_ok, at_limit, gnt_f, gnt_l;
   pend_t       pend, pend_nxt;
   logic [31:0] f_data_q, l_data_q;

   assign f_ok = addr_ok(bus.fetch_addr, MEM_WORDS);
   assign l_ok = addr_ok(bus.ld_addr, MEM_WORDS);

   // Grants are masked while reset is asserted so ready/mem_en sit at their reset values.
   assign gnt_f = rst_n && bus.fetch_req_valid && !bus.fetch_flush &&
                  (!bus.ld_req_valid || at_limit);
   assign gnt_l = rst_n && bus.ld_req_valid && !gnt_f;

   assign bus.fetch_req_ready = gnt_f;
   assign bus.ld_req_ready    = gnt_l;

   imem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (bus.fetch_req_valid && !gnt_f && !bus.fetch_flush),
      .clr      (gnt_f),
      .at_limit (at_limit)
   );

   // Erroring requests are granted but never touch the memory.
   assign bus.mem_en    = (gnt_f && f_ok) || (gnt_l && l_ok);
   assign bus.mem_we    = (gnt_l && l_ok && bus.ld_we) ? bus.ld_wstrb : 4'b0000;
   assign bus.mem_addr  = gnt_f ? bus.fetch_addr[AW+1:2] : bus.ld_addr[AW+1:2];
   assign bus.mem_wdata = bus.ld_wdata;

   always_comb begin
      pend_nxt = IDLE;
      if (gnt_f)      pend_nxt = f_ok ? F_RD : F_ERR;
      else if (gnt_l) pend_nxt = !l_ok ? L_ERR : (bus.ld_we ? L_WR : L_RD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= IDLE;
      else        pend <= pend_nxt;
   end

   // Fetch response; a redirect in the response cycle kills the pulse only.
   assign bus.fetch_rsp_valid = ((pend == F_RD) || (pend == F_ERR)) && !bus.fetch_flush;
   assign bus.fetch_rsp_err   = bus.fetch_rsp_valid && (pend == F_ERR);
   assign bus.fetch_rsp_data  = (pend == F_RD)  ? bus.mem_rdata :
                                (pend == F_ERR) ? NOP_INSTR : f_data_q;

   assign bus.ld_rsp_valid = (pend == L_RD) || (pend == L_WR) || (pend == L_ERR);
   assign bus.ld_rsp_err   = (pend == L_ERR);
   assign bus.ld_rsp_data  = (pend == L_RD) ? bus.mem_rdata :
                             ((pend == L_WR) || (pend == L_ERR)) ? 32'd0 : l_data_q;

   // Data holders keep the last presented word while no response is due.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_data_q <= NOP_INSTR;
         l_data_q <= 32'd0;
      end else begin
         f_data_q <= bus.fetch_rsp_data;
         l_data_q <= bus.ld_rsp_data;
      end
   end
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised scoreboard bench for imem_arbiter with a word-array reference model.
module tb_imem_arbiter;
   import imem_pkg::*;

   localparam int MEM_WORDS    = 512;
   localparam int STARVE_LIMIT = 4;
   localparam int AW           = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_arbiter_if #(.AW(AW)) bus();

   imem_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Synchronous single-port memory, one-cycle read latency.
   logic [31:0] ram [MEM_WORDS];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we == 4'b0000) bus.mem_rdata <= ram[bus.mem_addr];
         else for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   typedef struct {
      logic        rst, fv, fl, lv, lwe;
      logic [31:0] fa, la, lwd;
      logic [3:0]  lws;
   } stim_t;

   typedef struct {
      int          cyc;
      logic        kill;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic [31:0] mdl [MEM_WORDS];
   rsp_t        fq[$];
   rsp_t        lq[$];
   int          starve = 0;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'(4 * MEM_WORDS));
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b1, fv: 1'b0, fl: 1'b0, lv: 1'b0, lwe: 1'b0,
            fa: 32'd0, la: 32'd0, lwd: 32'd0, lws: 4'd0};
      return s;
   endfunction

   function automatic stim_t fetch(input logic [31:0] a, input logic fl);
      stim_t s = idle();
      s.fv = 1'b1; s.fa = a; s.fl = fl;
      return s;
   endfunction

   function automatic stim_t ldw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      stim_t s = idle();
      s.lv = 1'b1; s.lwe = 1'b1; s.la = a; s.lwd = d; s.lws = st;
      return s;
   endfunction

   function automatic stim_t ldr(input logic [31:0] a);
      stim_t s = idle();
      s.lv = 1'b1; s.la = a;
      return s;
   endfunction

   // One cycle: drive at negedge, then predict grant and memory access and queue responses.
   task automatic step(input stim_t s);
      logic gf, gl, exp_en;
      rsp_t e;
      int   fw, lw;
      @(negedge clk);
      cyc++;
      rst_n               = s.rst;
      bus.fetch_req_valid = s.fv;
      bus.fetch_addr      = s.fa;
      bus.fetch_flush     = s.fl;
      bus.ld_req_valid    = s.lv;
      bus.ld_we           = s.lwe;
      bus.ld_addr         = s.la;
      bus.ld_wdata        = s.lwd;
      bus.ld_wstrb        = s.lws;
      #1;
      gf = 1'b0; gl = 1'b0;
      fw = int'(s.fa[AW+1:2]);
      lw = int'(s.la[AW+1:2]);
      if (!s.rst) begin
         fq.delete(); lq.delete(); starve = 0;
         chk("rst_fetch_data", bus.fetch_rsp_data, NOP_INSTR);
         chk("rst_ld_data", bus.ld_rsp_data, 32'd0);
         chk("rst_fetch_err", 32'(bus.fetch_rsp_err), 32'd0);
         chk("rst_ld_err", 32'(bus.ld_rsp_err), 32'd0);
         chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      end else begin
         if (s.fl && fq.size() > 0 && fq[0].cyc == cyc) fq[0].kill = 1'b1;
         if (s.fv && !s.fl && (!s.lv || starve == STARVE_LIMIT)) gf = 1'b1;
         else if (s.lv) gl = 1'b1;
         if (gf) starve = 0;
         else if (s.fv && !s.fl && starve < STARVE_LIMIT) starve++;
      end
      exp_en = (gf && ok(s.fa)) || (gl && ok(s.la));
      chk("fetch_ready", 32'(bus.fetch_req_ready), 32'(gf));
      chk("ld_ready", 32'(bus.ld_req_ready), 32'(gl));
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (gf) begin
         e.cyc = cyc + 1; e.kill = 1'b0; e.err = !ok(s.fa);
         e.data = e.err ? NOP_INSTR : mdl[fw];
         if (!e.err) begin
            chk("mem_addr_f", 32'(bus.mem_addr), 32'(fw));
            chk("mem_we_f", 32'(bus.mem_we), 32'd0);
         end
         fq.push_back(e);
      end
      if (gl) begin
         e.cyc = cyc + 1; e.kill = 1'b0; e.err = !ok(s.la); e.data = 32'd0;
         if (!e.err) begin
            chk("mem_addr_l", 32'(bus.mem_addr), 32'(lw));
            if (s.lwe) begin
               chk("mem_we_l", 32'(bus.mem_we), 32'(s.lws));
               chk("mem_wdata", bus.mem_wdata, s.lwd);
               for (int b = 0; b < 4; b++)
                  if (s.lws[b]) mdl[lw][8*b +: 8] = s.lwd[8*b +: 8];
            end else begin
               chk("mem_we_rd", 32'(bus.mem_we), 32'd0);
               e.data = mdl[lw];
            end
         end
         lq.push_back(e);
      end
   endtask

   // Monitor: every cycle, compare DUT responses with whatever the model queued for now.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (fq.size() > 0 && fq[0].cyc == cyc) begin
            e = fq.pop_front();
            chk("fetch_rsp_valid", 32'(bus.fetch_rsp_valid), 32'(!e.kill));
            if (!e.kill) begin
               chk("fetch_rsp_data", bus.fetch_rsp_data, e.data);
               chk("fetch_rsp_err", 32'(bus.fetch_rsp_err), 32'(e.err));
            end
         end else chk("fetch_rsp_idle", 32'(bus.fetch_rsp_valid), 32'd0);
         if (lq.size() > 0 && lq[0].cyc == cyc) begin
            e = lq.pop_front();
            chk("ld_rsp_valid", 32'(bus.ld_rsp_valid), 32'd1);
            chk("ld_rsp_data", bus.ld_rsp_data, e.data);
            chk("ld_rsp_err", 32'(bus.ld_rsp_err), 32'(e.err));
         end else chk("ld_rsp_idle", 32'(bus.ld_rsp_valid), 32'd0);
      end
   end

   initial begin
      stim_t s;
      logic [31:0] v;
      int r;
      bus.fetch_req_valid = 1'b0; bus.fetch_addr = '0; bus.fetch_flush = 1'b0;
      bus.ld_req_valid = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0;
      bus.ld_wdata = '0; bus.ld_wstrb = '0;
      s = idle(); s.rst = 1'b0;
      step(s); step(s);

      // Preload every word through the loader port.
      for (int w = 0; w < MEM_WORDS; w++) begin
         case (w)
            0:       v = 32'h07b0_0093;
            1:       v = 32'h0050_0113;
            2:       v = 32'h0020_81b3;
            5:       v = 32'hAAAA_AAAA;
            default: v = $urandom;
         endcase
         step(ldw(32'(4 * w), v, 4'hF));
      end

      // Back-to-back fetch stream.
      step(fetch(32'h0, 1'b0)); step(fetch(32'h4, 1'b0)); step(fetch(32'h8, 1'b0));

      // Contention: four loader wins then a forced fetch win, repeating.
      for (int i = 0; i < 10; i++) begin
         s = ldr(32'(4 * i)); s.fv = 1'b1; s.fa = 32'(4 * (i % 3));
         step(s);
         chk("contend_pattern", 32'(bus.fetch_req_ready), 32'(i % 5 == 4));
      end

      step(ldw(32'h10, 32'hDEAD_BEEF, 4'hF)); step(fetch(32'h10, 1'b0));
      step(ldw(32'h14, 32'h0000_CAFE, 4'b0011)); step(ldr(32'h14));
      step(ldw(32'h18, 32'h1234_5678, 4'b0000)); step(ldr(32'h18));

      // Error cases on both ports.
      step(fetch(32'h2, 1'b0)); step(fetch(32'h800, 1'b0));
      step(ldr(32'h3)); step(ldw(32'h1000, 32'hFFFF_FFFF, 4'hF)); step(ldr(32'h7FC));

      // Flush: response killed, fetch blocked, loader still granted.
      step(fetch(32'h0, 1'b0)); step(fetch(32'h4, 1'b1));
      s = fetch(32'h8, 1'b1); s.lv = 1'b1; s.la = 32'h8;
      step(s); step(idle());

      // Reset mid-flight drops the pending response.
      step(fetch(32'h4, 1'b0));
      s = fetch(32'h8, 1'b0); s.rst = 1'b0;
      step(s); step(idle()); step(idle());

      for (int i = 0; i < 1500; i++) begin
         s = idle();
         s.fv = ($urandom_range(0, 3) != 0);
         s.fl = ($urandom_range(0, 6) == 0);
         s.lv = ($urandom_range(0, 1) == 1);
         s.lwe = ($urandom_range(0, 2) == 0);
         s.lwd = $urandom;
         s.lws = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         s.fa = (r < 7) ? 32'(4 * $urandom_range(0, 63)) :
                (r == 7) ? 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
                (r == 8) ? 32'(2048 + 4 * $urandom_range(0, 100)) : $urandom;
         r = $urandom_range(0, 9);
         s.la = (r < 8) ? 32'(4 * $urandom_range(0, 63)) :
                (r == 8) ? 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
                32'(2048 + 4 * $urandom_range(0, 100));
         s.rst = ($urandom_range(0, 199) != 0);
         step(s);
      end

      step(idle()); step(idle());
      chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
      chk("ld_queue_drained", 32'(lq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
